serial_word_deserializer: RTL and testbench
===========================================

// Module: serial_word_deserializer
// PURPOSE
//   Receive end of the MSB-first serial link driven by the team's N-bit shift register (serial_out = MSB, left shift).
//   Collects framed serial bits into N-bit words and presents each word on a valid/ready output with a 1-word buffer.
//   Reports framing and overrun errors as sticky flags.
//   Sits between the serial link and the parallel consumer logic.
// PARAMETERS
//   N          4   word width in bits, N >= 2
//   MSB_FIRST  1   1: first received bit lands in word[N-1]; 0: first bit lands in word[0]
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   bit_valid    in   1        bit_in/sof are valid this cycle
//   bit_in       in   1        serial data bit
//   sof          in   1        start-of-frame; qualifies the first bit of a word
//   word_out     out  N        assembled word, stable while word_valid=1
//   word_valid   out  1        word_out holds an unconsumed word
//   word_ready   in   1        consumer accepts; transfer when word_valid & word_ready
//   busy         out  1        a word is partially received (state SHIFT)
//   framing_err  out  1        sticky; sof seen mid-word
//   overrun_err  out  1        sticky; completed word dropped because buffer full
//   clear_err    in   1        synchronous clear of both sticky flags
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, bit count=0, shift reg=0, word_out=0.
//     Also word_valid=0, busy=0, framing_err=0, overrun_err=0.
//   FSM (2 states):
//     IDLE: bit_valid & sof -> load bit as bit 1 of word, count=1, go SHIFT.
//       bit_valid & !sof -> bit ignored, stay IDLE.
//     SHIFT: bit_valid & !sof -> shift bit in, count++.
//       When count reaches N, the word is complete; go IDLE.
//   Mid-word resync (SHIFT, bit_valid & sof):
//     Discard the partial word, set framing_err.
//     Treat the bit as bit 1 of a new word (count=1, stay SHIFT).
//   Cycles with bit_valid=0 hold all state; no timeout.
//   Shift order:
//     MSB_FIRST=1: sr <= {sr[N-2:0], bit_in}.
//     MSB_FIRST=0: sr <= {bit_in, sr[N-1:1]}.
//   Completion:
//     word_valid rises the cycle after the Nth bit is sampled (latency 1 clk from the last bit).
//     word_out is updated in the same edge.
//   Buffer: 1 entry.
//     A completed word is written if the buffer is empty, or if it drains in the same cycle (word_valid & word_ready).
//     Back-to-back words at full rate therefore never overrun when word_ready=1.
//     Otherwise the new word is dropped: buffer keeps the old word and overrun_err is set.
//   Handshake:
//     word_valid stays high and word_out stays stable until word_ready=1.
//     word_valid must not depend combinationally on word_ready.
//   Sticky errors: set on the event and held until clear_err=1.
//     If set and clear occur in the same cycle, set wins.
//   busy = (state==SHIFT), registered.
//   Bit count is $clog2(N+1) bits wide and never exceeds N.
//   Reset mid-word: the partial word and buffered word are lost.
//     After rst deasserts, the block waits for the next sof.
// STRUCTURE
//   Package serdes_pkg:
//     typedef enum logic {DES_IDLE, DES_SHIFT} des_state_t
//     function cnt_w(N) = $clog2(N+1)
//   Sub-module deser_out_buf (1-entry valid/ready holding register: wr_en, wr_data, rd_ready).
//   Shift register, counter and FSM are in the top module.
// TESTING (N=4, MSB_FIRST=1 unless noted)
//   1. sof+bits 1,0,1,1 consecutive, word_ready=1 -> word_out=4'hB, word_valid high exactly 1 clk after bit 4.
//   2. Same bits with bit_valid gaps of 3 clks between bits -> word_out=4'hB; busy=1 from bit 1 until bit 4.
//   3. Two words 4'hB then 4'h6 back-to-back, word_ready=0 -> word_out stays 4'hB, overrun_err=1.
//      Then word_ready=1 -> 4'hB consumed, no further word.
//   4. sof+1,0 then sof+0,1,1,0 -> framing_err=1, word_out=4'h6.
//      Then clear_err -> framing_err=0 next clk.
//   5. MSB_FIRST=0, sof+bits 1,0,1,1 -> word_out=4'hD.
//   6. rst pulse after 2 bits, then bits without sof -> nothing emitted, all outputs 0.
//      Then sof+0,0,0,1 -> word_out=4'h1.

Source files
------------

// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and helpers for the serial word deserializer.
//   des_state_t : receive FSM states (IDLE waits for sof, SHIFT collects bits)
//   cnt_w(n)    : width of a counter that must hold values 0..n
package serdes_pkg;

  typedef enum logic {DES_IDLE, DES_SHIFT} des_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Serial-in / word-out bus of the deserializer.
//   bit_valid, bit_in, sof : serial side, driven by the link
//   word_out, word_valid   : word side, driven by the deserializer
//   word_ready             : word side, driven by the consumer
// The slave modport is the deserializer's view; master is the environment's view.
interface serial_word_deserializer_if #(
  parameter int N = 4
);
  logic         bit_valid;
  logic         bit_in;
  logic         sof;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         word_ready;

  modport master (
    output bit_valid, bit_in, sof, word_ready,
    input  word_out, word_valid
  );

  modport slave (
    input  bit_valid, bit_in, sof, word_ready,
    output word_out, word_valid
  );
endinterface

// File: rtl/serial_word_deserializer_buf.sv
// deser_out_buf: single-entry valid/ready holding register.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : a completed word is offered this cycle
//   wr_data   : the offered word
//   rd_ready  : consumer accepts the held word this cycle
//   rd_valid  : a word is held
//   rd_data   : the held word, stable while rd_valid=1
//   wr_drop   : offered word is dropped because the entry is full and not draining
module deser_out_buf #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         wr_drop
);

  logic accept;

  // A write is taken when the entry is empty or is being read out this same cycle,
  // so back-to-back words at full rate flow through without loss.
  assign accept  = wr_en && (!rd_valid || rd_ready);
  assign wr_drop = wr_en && rd_valid && !rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (accept) begin
      rd_valid <= 1'b1;
      rd_data  <= wr_data;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: assembles framed serial bits into N-bit words.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : bit_valid/bit_in/sof serial input, word_out/word_valid/word_ready output
//   busy         : a word is partially received
//   framing_err  : sticky, sof arrived in the middle of a word
//   overrun_err  : sticky, a completed word was dropped because the buffer was full
//   clear_err    : synchronous clear of both sticky flags (a same-cycle set wins)
// MSB_FIRST=1 places the first received bit in word[N-1], otherwise in word[0].
module serial_word_deserializer
  import serdes_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_word_deserializer_if.slave    bus,
  output logic                         busy,
  output logic                         framing_err,
  output logic                         overrun_err,
  input  logic                         clear_err
);

  localparam int CW = cnt_w(N);

  des_state_t      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N-1:0]    sr, sr_nxt;
  logic [N-1:0]    sr_base, sr_shift;
  logic            word_done;
  logic            resync;
  logic            drop;

  // A new frame (sof) shifts into a cleared register so no stale partial bits survive.
  always_comb begin
    sr_base = (state == DES_SHIFT && !bus.sof) ? sr : '0;
    if (MSB_FIRST) sr_shift = {sr_base[N-2:0], bus.bit_in};
    else           sr_shift = {bus.bit_in, sr_base[N-1:1]};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    word_done = 1'b0;
    resync    = 1'b0;
    if (bus.bit_valid) begin
      case (state)
        DES_IDLE: begin
          if (bus.sof) begin
            sr_nxt    = sr_shift;
            cnt_nxt   = CW'(1);
            state_nxt = DES_SHIFT;
          end
        end
        DES_SHIFT: begin
          sr_nxt = sr_shift;
          if (bus.sof) begin
            resync  = 1'b1;
            cnt_nxt = CW'(1);
          end else begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              word_done = 1'b1;
              state_nxt = DES_IDLE;
            end
          end
        end
        default: state_nxt = DES_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DES_IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  // The completed word goes straight from the shift path into the buffer,
  // so word_valid rises one clock after the last bit is sampled.
  deser_out_buf #(
    .W (N)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (word_done),
    .wr_data  (sr_nxt),
    .rd_ready (bus.word_ready),
    .rd_valid (bus.word_valid),
    .rd_data  (bus.word_out),
    .wr_drop  (drop)
  );

  assign busy = (state == DES_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (resync)         framing_err <= 1'b1;
      else if (clear_err) framing_err <= 1'b0;
      if (drop)           overrun_err <= 1'b1;
      else if (clear_err) overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Testbench for serial_word_deserializer: one MSB-first and one LSB-first instance
// receive the same bit stream; a frame-level reference model predicts words and flags.
module tb_serial_word_deserializer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bv = 1'b0, bi = 1'b0, sof = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic busy1, fe1, oe1, busy0, fe0, oe0;

  always #5 clk = ~clk;

  serial_word_deserializer_if #(.N(N)) if1 ();
  serial_word_deserializer_if #(.N(N)) if0 ();

  assign if1.bit_valid  = bv;
  assign if1.bit_in     = bi;
  assign if1.sof        = sof;
  assign if1.word_ready = rdy;
  assign if0.bit_valid  = bv;
  assign if0.bit_in     = bi;
  assign if0.sof        = sof;
  assign if0.word_ready = rdy;

  serial_word_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1),
    .framing_err(fe1), .overrun_err(oe1), .clear_err(clr)
  );

  serial_word_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .busy(busy0),
    .framing_err(fe0), .overrun_err(oe0), .clear_err(clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the receiver.
  bit           m_full, m_ferr, m_oerr, m_inframe;
  bit           mbits[$];
  logic [N-1:0] q1[$], q0[$];
  logic [N-1:0] last1, last0;
  logic [N-1:0] w1, w0;
  bit           drain, done, fset, oset;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 0; m_ferr = 0; m_oerr = 0; m_inframe = 0;
      mbits.delete(); q1.delete(); q0.delete();
    end else begin
      drain = m_full && rdy;
      done = 0; fset = 0; oset = 0;
      if (bv) begin
        if (sof) begin
          fset = m_inframe;
          mbits.delete();
          mbits.push_back(bi);
          m_inframe = 1;
        end else if (m_inframe) begin
          mbits.push_back(bi);
          if (mbits.size() == N) begin
            done = 1;
            m_inframe = 0;
          end
        end
      end
      if (done) begin
        for (int i = 0; i < N; i++) begin
          w1[N-1-i] = mbits[i];
          w0[i]     = mbits[i];
        end
        mbits.delete();
        if (!m_full || rdy) begin
          q1.push_back(w1);
          q0.push_back(w0);
          m_full = 1;
        end else begin
          oset = 1;
        end
      end else if (drain) begin
        m_full = 0;
      end
      m_ferr = fset ? 1'b1 : (clr ? 1'b0 : m_ferr);
      m_oerr = oset ? 1'b1 : (clr ? 1'b0 : m_oerr);
    end
  end

  // Monitor: compares status every cycle and pops a word whenever a transfer is about to occur.
  always @(negedge clk) begin
    chk("valid1", if1.word_valid, m_full);
    chk("valid0", if0.word_valid, m_full);
    chk("busy1", busy1, m_inframe);
    chk("busy0", busy0, m_inframe);
    chk("framing1", fe1, m_ferr);
    chk("framing0", fe0, m_ferr);
    chk("overrun1", oe1, m_oerr);
    chk("overrun0", oe0, m_oerr);
    if (!rst && if1.word_valid && rdy) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL word1: got %0h expected no word", if1.word_out);
      end else begin
        checks--;
        chk("word1", if1.word_out, q1.pop_front());
      end
      last1 = if1.word_out;
    end
    if (!rst && if0.word_valid && rdy) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL word0: got %0h expected no word", if0.word_out);
      end else begin
        checks--;
        chk("word0", if0.word_out, q0.pop_front());
      end
      last0 = if0.word_out;
    end
  end

  task automatic cyc(input logic v, input logic b, input logic s, input logic r, input logic c);
    @(posedge clk);
    #2;
    bv = v; bi = b; sof = s; rdy = r; clr = c;
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  // Sends w[N-1] first; the MSB-first instance reassembles w.
  task automatic send(input logic [N-1:0] w, input int gap, input logic r);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, w[N-1-i], (i == 0), r, 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2;
    rst = 1'b1; bv = 1'b0; sof = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_valid", if1.word_valid, 1'b0);
    chk("rst_word", if1.word_out, 4'h0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_errs", {fe1, oe1}, 2'b00);

    // Consecutive bits 1,0,1,1
    send(4'hB, 0, 1'b1);
    idle(3, 1'b1);
    chk("t1_word", last1, 4'hB);

    // Gapped bits
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("t2_busy_mid", busy1, 1'b1);
    idle(2, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t2_busy_late", busy1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t2_word", last1, 4'hB);
    chk("t2_busy_end", busy1, 1'b0);

    // Overrun with consumer stalled
    send(4'hB, 0, 1'b0);
    send(4'h6, 0, 1'b0);
    idle(3, 1'b0);
    chk("t3_overrun", oe1, 1'b1);
    chk("t3_hold", if1.word_out, 4'hB);
    chk("t3_valid", if1.word_valid, 1'b1);
    idle(3, 1'b1);
    chk("t3_drained", last1, 4'hB);
    chk("t3_empty", if1.word_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("t3_clear", oe1, 1'b0);

    // Mid-word resync
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'h6, 0, 1'b1);
    idle(3, 1'b1);
    chk("t4_framing", fe1, 1'b1);
    chk("t4_word", last1, 4'h6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("t4_clear", fe1, 1'b0);

    // LSB-first instance sees the same bits
    send(4'hB, 0, 1'b1);
    idle(3, 1'b1);
    chk("t5_lsb_word", last0, 4'hD);

    // Reset mid-word, then bits without sof
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_pulse();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("t6_valid", if1.word_valid, 1'b0);
    chk("t6_word", if1.word_out, 4'h0);
    chk("t6_busy", busy1, 1'b0);
    chk("t6_errs", {fe1, oe1}, 2'b00);
    send(4'h1, 0, 1'b1);
    idle(3, 1'b1);
    chk("t6_word_after", last1, 4'h1);
    chk("t6_lsb_after", last0, 4'h8);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) rst_pulse();
      else cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0));
    end
    idle(5, 1'b1);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
